multiplicador_param: RTL and testbench
======================================

// Module: multiplicador_param
// PURPOSE
//  Parametrised sequential multiplier; successor of the 8-bit ROM/add-sub multiplier.
//  Splits A and B into DIGIT-bit digits and multiplies one digit pair per cycle.
//  The digit product is combinational: a DIGITxDIGIT ROM-equivalent table.
//  Shifted digit products accumulate into a 2*WIDTH accumulator.
//  Adds signed (two's complement) mode and a BUSY flag; feeds datapaths needing WxW products.
// PARAMETERS
//  WIDTH  8  operand width in bits; WIDTH % DIGIT == 0, else elaboration error ($error)
//  DIGIT  4  digit width per partial product; N = WIDTH/DIGIT digits per operand
// PORTS
//  CLK     in   1        single clock, rising edge
//  RST     in   1        synchronous reset, active-high
//  START   in   1        request; sampled at posedge only while IDLE
//  SIGNED  in   1        1 = operands two's complement, 0 = unsigned; latched with START
//  A       in   WIDTH    multiplicand, latched with START
//  B       in   WIDTH    multiplier, latched with START
//  BUSY    out  1        high while an operation is in progress
//  DONE    out  1        one-cycle pulse, RES valid
//  RES     out  2*WIDTH  product register; holds value until next result write
// BEHAVIOUR
//  Reset (RST=1 at posedge): state=IDLE, RES=0, DONE=0, BUSY=0, accumulator=0, digit indices=0.
//  RST has priority over START. RST mid-operation aborts it: no DONE, RES returns to 0.
//  FSM IDLE -> CALC -> FIX -> IDLE. Registered outputs; no combinational path from inputs to outputs.
//  IDLE with START=1 at edge k:
//   - latch mA=|A|, mB=|B| (unsigned WIDTH-bit magnitudes; -2^(W-1) gives 2^(W-1))
//   - latch NEG = SIGNED & (A[W-1] ^ B[W-1]); SIGNED=0 takes A,B as-is and sets NEG=0
//   - clear acc; set i=j=0; BUSY=1; go to CALC
//  CALC, one edge per pair:
//   - acc += (mA digit i * mB digit j) << ((i+j)*DIGIT)
//   - j increments first; at j=N-1, j wraps to 0 and i increments
//   - after pair (N-1,N-1), go to FIX. CALC occupies exactly N*N edges.
//  FIX: RES <= NEG ? (~acc + 1) : acc, in 2*WIDTH bits; DONE <= 1; BUSY <= 0; go to IDLE.
//  Latency: START sampled at edge k gives DONE=1 and the new RES after edge k+N*N+1.
//   - For WIDTH=8, DIGIT=4: edge k+5.
//  DONE is high for exactly one cycle, then 0. It is not asserted again until the next operation.
//  START while BUSY=1 is ignored; it is not queued and latched operands are unaffected.
//  START in the DONE cycle (state already IDLE) is accepted, giving back-to-back ops with no bubble.
//  Width rules: accumulator is 2*WIDTH unsigned. The max magnitude product (2^W-1)^2 fits without overflow.
//  Signed result range [-(2^(W-1))*(2^(W-1)-1), 2^(2W-2)] fits in 2*WIDTH two's complement.
//  Negating a zero product gives 0; there is no -0 special case.
//  A, B and SIGNED may change freely after the START edge; only the latched copies are used.
// TESTING
//  1. W=8,D=4, unsigned, A=255, B=255, START 1 cycle -> BUSY 5 cycles; DONE pulse at k+5; RES=16'hFE01.
//  2. Signed A=8'h80 (-128), B=8'h80 -> RES=16'h4000. Signed A=8'hFD (-3), B=7 -> RES=16'hFFEB (-21).
//  3. Signed A=8'hFB (-5), B=0 -> RES=16'h0000. Unsigned A=8'hFB, B=2 -> RES=16'h01F6.
//  4. START held high for the whole op with A,B changed mid-op -> single result from first operands.
//     DONE pulses once; a second op starts in the DONE cycle and completes 5 cycles later.
//  5. RST pulsed at CALC cycle 2 -> no DONE; RES=0; BUSY=0 next cycle.
//     A following START gives the correct product.
//  6. W=16,D=4, unsigned A=16'hFFFF, B=16'hFFFF -> DONE at k+17, RES=32'hFFFE0001.
//     Signed -1 * -1 -> RES=32'h00000001.
//  Bench uses a reference model (A*B, $signed when SIGNED=1) to check RES.
//  Random regression: 1000 ops per mode with RES compared against the model.

Source files
------------

// File: rtl/multiplicador_param_if.sv
// Operand/result bundle for the parametrised sequential multiplier.
// The master issues requests and the slave (the multiplier) returns the product.
interface multiplicador_param_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;

  modport master (
    output start, sgn, a, b,
    input  busy, done, res
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, res
  );
endinterface

// File: rtl/multiplicador_param.sv
// Sequential WIDTHxWIDTH multiplier: one DIGITxDIGIT partial product per cycle,
// shifted into a 2*WIDTH accumulator. Signed mode works on magnitudes and fixes the sign at the end.
module multiplicador_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplicador_param_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("multiplicador_param: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   magA_q, magA_d;
  logic [WIDTH-1:0]   magB_q, magB_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]      i_q, i_d;
  logic [IW-1:0]      j_q, j_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [DIGIT-1:0]   digitA;
  logic [DIGIT-1:0]   digitB;
  logic [2*DIGIT-1:0] digitProd;
  logic [2*WIDTH-1:0] partial;

  // Current digit pair and its product, already placed at its weight (i+j)*DIGIT.
  always_comb begin
    digitA    = DIGIT'(magA_q >> (DIGIT * int'(i_q)));
    digitB    = DIGIT'(magB_q >> (DIGIT * int'(j_q)));
    digitProd = (2*DIGIT)'(digitA) * (2*DIGIT)'(digitB);
    partial   = (2*WIDTH)'(digitProd) << (DIGIT * (int'(i_q) + int'(j_q)));
  end

  always_comb begin
    state_d = state_q;
    magA_d  = magA_q;
    magB_d  = magB_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Magnitudes as unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
          magA_d  = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
          magB_d  = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
          neg_d   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end

      CALC: begin
        acc_d = acc_q + partial;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          if (i_q == IW'(N - 1)) begin
            i_d     = '0;
            state_d = FIX;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      FIX: begin
        res_d   = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      magA_q  <= '0;
      magB_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      magA_q  <= magA_d;
      magB_q  <= magB_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
endmodule

// File: tb/tb_multiplicador_param.sv
// Bench for multiplicador_param at 8/4 and 16/4: directed timing cases plus random ops,
// with results checked by a scoreboard against an arithmetic product model.
module tb_multiplicador_param;
  logic clk;
  logic rst;

  multiplicador_param_if #(.WIDTH(8))  bus8 ();
  multiplicador_param_if #(.WIDTH(16)) bus16 ();

  multiplicador_param #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  multiplicador_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] expQ8[$];
  logic [31:0] expQ16[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product of the two operands read as w-bit numbers (signed or not), kept to 2*w bits.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input bit s);
    longint mask, sa, sb, p;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic getDone(input int sel);
    return (sel == 8) ? bus8.done : bus16.done;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 8) ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic [31:0] getRes(input int sel);
    return (sel == 8) ? 32'(bus8.res) : bus16.res;
  endfunction

  task automatic driveBus(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                          input bit s);
    if (sel == 8) begin
      bus8.start = st;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.sgn   = s;
    end else begin
      bus16.start = st;
      bus16.a     = a;
      bus16.b     = b;
      bus16.sgn   = s;
    end
  endtask

  function automatic void pushExp(input int sel, input logic [15:0] a, input logic [15:0] b,
                                  input bit s);
    logic [31:0] e;
    e = model(sel, a, b, s);
    if (sel == 8) expQ8.push_back(e[15:0]);
    else          expQ16.push_back(e);
  endfunction

  // Called just after a rising edge; returns just after the edge that samples START.
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                               input bit s, input bit track);
    driveBus(sel, 1'b1, a, b, s);
    if (track) pushExp(sel, a, b, s);
    @(posedge clk); #1;
    driveBus(sel, 1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  // Counts edges until DONE is seen and how many of those samples showed BUSY.
  task automatic waitDone(input int sel, output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = getBusy(sel) ? 1 : 0;
    while (!getDone(sel) && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (getBusy(sel)) busyCycles++;
    end
    if (!getDone(sel)) checkOutput("done timeout", 32'(cycles), 32'hFFFF_FFFF);
  endtask

  // Scoreboard monitors: each DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus8.done) begin
      if (expQ8.size() == 0) checkOutput("unexpected done8", 32'd1, 32'd0);
      else                   checkOutput("res8", 32'(bus8.res), 32'(expQ8.pop_front()));
    end
    if (!rst && bus16.done) begin
      if (expQ16.size() == 0) checkOutput("unexpected done16", 32'd1, 32'd0);
      else                    checkOutput("res16", bus16.res, expQ16.pop_front());
    end
  end

  initial begin
    int cyc, busyCyc, doneSeen, sel, pick;
    logic [15:0] ra, rb, maxV, minV;
    bit rs;

    rst = 1'b1;
    driveBus(8, 1'b0, 16'h0, 16'h0, 1'b0);
    driveBus(16, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy8", 32'(bus8.busy), 32'd0);
    checkOutput("reset done8", 32'(bus8.done), 32'd0);
    checkOutput("reset res8", 32'(bus8.res), 32'd0);
    checkOutput("reset res16", bus16.res, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned max * max with exact latency and BUSY length.
    applyStimulus(8, 16'hFF, 16'hFF, 1'b0, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("latency 8x8", 32'(cyc), 32'd5);
    checkOutput("busy cycles 8x8", 32'(busyCyc), 32'd5);
    checkOutput("res FE01", getRes(8), 32'h0000_FE01);
    @(posedge clk); #1;
    checkOutput("done one pulse", 32'(bus8.done), 32'd0);

    applyStimulus(8, 16'h80, 16'h80, 1'b1, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("res -128*-128", getRes(8), 32'h0000_4000);
    applyStimulus(8, 16'hFD, 16'h07, 1'b1, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("res -3*7", getRes(8), 32'h0000_FFEB);
    applyStimulus(8, 16'hFB, 16'h00, 1'b1, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("res -5*0", getRes(8), 32'h0000_0000);
    applyStimulus(8, 16'hFB, 16'h02, 1'b0, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("res 251*2", getRes(8), 32'h0000_01F6);

    // START held through the op while operands change: second op only from the DONE cycle.
    @(posedge clk); #1;
    driveBus(8, 1'b1, 16'h0C, 16'h0D, 1'b0);
    pushExp(8, 16'h0C, 16'h0D, 1'b0);
    @(posedge clk); #1;
    driveBus(8, 1'b1, 16'hA5, 16'h3C, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("held start latency", 32'(cyc), 32'd5);
    pushExp(8, 16'hA5, 16'h3C, 1'b1);
    @(posedge clk); #1;
    driveBus(8, 1'b0, 16'h00, 16'h00, 1'b0);
    checkOutput("busy in b2b op", 32'(bus8.busy), 32'd1);
    waitDone(8, cyc, busyCyc);
    checkOutput("back-to-back latency", 32'(cyc), 32'd5);

    // Abort in the second CALC cycle.
    @(posedge clk); #1;
    applyStimulus(8, 16'h77, 16'h99, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy", 32'(bus8.busy), 32'd0);
    checkOutput("abort res", getRes(8), 32'd0);
    doneSeen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus8.done) doneSeen++;
    end
    checkOutput("abort no done", 32'(doneSeen), 32'd0);
    applyStimulus(8, 16'h13, 16'h0B, 1'b0, 1'b1);
    waitDone(8, cyc, busyCyc);
    checkOutput("post-abort res", getRes(8), 32'h0000_00D1);

    // Wider instance.
    @(posedge clk); #1;
    applyStimulus(16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    waitDone(16, cyc, busyCyc);
    checkOutput("latency 16x16", 32'(cyc), 32'd17);
    checkOutput("res FFFE0001", getRes(16), 32'hFFFE_0001);
    applyStimulus(16, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    waitDone(16, cyc, busyCyc);
    checkOutput("res -1*-1", getRes(16), 32'h0000_0001);

    // Random regression, both modes, with occasional corner operands; ops issued back to back.
    for (int w = 0; w < 2; w++) begin
      sel  = (w == 0) ? 8 : 16;
      maxV = (sel == 8) ? 16'h00FF : 16'hFFFF;
      minV = (sel == 8) ? 16'h0080 : 16'h8000;
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < ((sel == 8) ? 1000 : 150); n++) begin
          pick = $urandom_range(0, 9);
          ra = (pick == 0) ? maxV : (pick == 1) ? minV : 16'($urandom) & maxV;
          pick = $urandom_range(0, 9);
          rb = (pick == 0) ? maxV : (pick == 1) ? 16'h0 : 16'($urandom) & maxV;
          rs = (m == 1);
          applyStimulus(sel, ra, rb, rs, 1'b1);
          waitDone(sel, cyc, busyCyc);
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard8 drained", 32'(expQ8.size()), 32'd0);
    checkOutput("scoreboard16 drained", 32'(expQ16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
